gate_sequencer: RTL

- Parametrised gate-program controller for the stabilizer core. It replaces the fixed two-state gate-info-update logic and the testbench-driven gate feed.
- Holds a DEPTH-entry gate program, issues each gate's type and qubit positions to the core, and pulses update_gate_info on each canonical pass.
- Advances through the program on core handshakes and logs the anticommute outcome of every measurement gate.
- Sits between the host/testbench and the stabilizer top.

---
 rtl/stabilizer_pkg.sv | 26 ++
 rtl/gate_sequencer_if.sv | 23 ++
 rtl/gate_sequencer_gate_mem.sv | 23 ++
 rtl/gate_sequencer.sv | 116 +++++++++++
 4 files changed

// File: rtl/stabilizer_pkg.sv
// stabilizer_pkg: gate encodings, gate program entry and sequencer states
// Shared by gate_mem, gate_sequencer and the core-side interface users.
package stabilizer_pkg;
    localparam logic [1:0] GATE_H    = 2'd0;
    localparam logic [1:0] GATE_P    = 2'd1;
    localparam logic [1:0] GATE_CNOT = 2'd2;
    localparam logic [1:0] GATE_MEAS = 2'd3;

    typedef struct packed {
        logic [1:0]  gate_type;
        logic [31:0] pos;
        logic [31:0] pos2;
    } gate_entry_t;

    typedef logic [2:0] state_t;
    localparam state_t S_IDLE       = 3'd0;
    localparam state_t S_ISSUE      = 3'd1;
    localparam state_t S_WAIT_CANON = 3'd2;
    localparam state_t S_WAIT_BUF   = 3'd3;
    localparam state_t S_DONE       = 3'd4;

    // pos2 only addresses a qubit on CNOT, so it is ignored for other gates
    function automatic logic pos_illegal(gate_entry_t g, logic [31:0] nq);
        return g.pos >= nq || (g.gate_type == GATE_CNOT && g.pos2 >= nq);
    endfunction
endpackage

// File: rtl/gate_sequencer_if.sv
// gate_sequencer_if: gate feed and handshake between sequencer and stabilizer core
// master (sequencer): drives gate_type/qubit_pos/qubit_pos2/core_start/update_gate_info,
// receives canonical_valid/buffer_valid/flag_anticommute; slave is the core side.
interface gate_sequencer_if;
    logic [1:0]  gate_type;
    logic [31:0] qubit_pos;
    logic [31:0] qubit_pos2;
    logic        core_start;
    logic        update_gate_info;
    logic        canonical_valid;
    logic        buffer_valid;
    logic        flag_anticommute;

    modport master (
        output gate_type, qubit_pos, qubit_pos2, core_start, update_gate_info,
        input  canonical_valid, buffer_valid, flag_anticommute
    );

    modport slave (
        input  gate_type, qubit_pos, qubit_pos2, core_start, update_gate_info,
        output canonical_valid, buffer_valid, flag_anticommute
    );
endinterface

// File: rtl/gate_sequencer_gate_mem.sv
// gate_mem: DEPTH-entry gate program register file
// clk; we/waddr/wdata synchronous write; raddr/rdata combinational read
// (out-of-range reads return 0 so a look-ahead past the last entry is harmless).
module gate_mem
    import stabilizer_pkg::*;
#(
    parameter int DEPTH = 30,
    parameter int IDX_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  gate_entry_t      wdata,
    input  logic [IDX_W-1:0] raddr,
    output gate_entry_t      rdata
);
    gate_entry_t mem [DEPTH];

    always_ff @(posedge clk)
        if (we && waddr < IDX_W'(DEPTH)) mem[waddr] <= wdata;

    assign rdata = raddr < IDX_W'(DEPTH) ? mem[raddr] : '0;
endmodule

// File: rtl/gate_sequencer.sv
// gate_sequencer: loads a gate program and steps the stabilizer core through it
// clk/rst; host: wr_en/wr_gate_type/wr_qubit_pos/wr_qubit_pos2 append, clear, run, abort;
// core: gate_sequencer_if master (gate feed, core_start, update_gate_info, valids, flag);
// status: busy, done, gate_index, gate_count, full, err, meas_flags.
module gate_sequencer
    import stabilizer_pkg::*;
#(
    parameter int NUM_QUBIT = 3,
    parameter int DEPTH     = 30,
    parameter int IDX_W     = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [1:0]         wr_gate_type,
    input  logic [31:0]        wr_qubit_pos,
    input  logic [31:0]        wr_qubit_pos2,
    input  logic               clear,
    input  logic               run,
    input  logic               abort,
    gate_sequencer_if.master   core,
    output logic               busy,
    output logic               done,
    output logic [IDX_W-1:0]   gate_index,
    output logic [IDX_W-1:0]   gate_count,
    output logic               full,
    output logic               err,
    output logic [DEPTH-1:0]   meas_flags
);
    state_t           state;
    gate_entry_t      cur, rd_entry, wr_entry;
    logic [IDX_W-1:0] rd_addr, cmp_idx;
    logic             cmp_meas, cmp_last;
    logic             idle_like, is_last, wr_ok, do_clear;

    assign wr_entry  = {wr_gate_type, wr_qubit_pos, wr_qubit_pos2};
    assign idle_like = state == S_IDLE || state == S_DONE;
    assign busy      = state == S_ISSUE || state == S_WAIT_CANON || state == S_WAIT_BUF;
    assign done      = state == S_DONE;
    assign full      = gate_count == IDX_W'(DEPTH);
    assign is_last   = gate_index == gate_count - IDX_W'(1);
    assign do_clear  = idle_like && clear;
    assign wr_ok     = idle_like && wr_en && !full && !clear;
    // Look ahead one entry while waiting for canonical so the next gate loads on the advance edge
    assign rd_addr   = state == S_WAIT_CANON ? gate_index + IDX_W'(1) : '0;

    assign core.gate_type        = cur.gate_type;
    assign core.qubit_pos        = cur.pos;
    assign core.qubit_pos2       = cur.pos2;
    assign core.core_start       = state == S_ISSUE && !abort;
    assign core.update_gate_info = state == S_WAIT_CANON && core.canonical_valid && !abort;

    gate_mem #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_mem (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (gate_count),
        .wdata (wr_entry),
        .raddr (rd_addr),
        .rdata (rd_entry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cur        <= '0;
            gate_index <= '0;
            gate_count <= '0;
            err        <= 1'b0;
            meas_flags <= '0;
            cmp_idx    <= '0;
            cmp_meas   <= 1'b0;
            cmp_last   <= 1'b0;
        end else begin
            if (do_clear) begin
                gate_count <= '0;
                err        <= 1'b0;
                meas_flags <= '0;
            end else begin
                if (wr_ok) gate_count <= gate_count + IDX_W'(1);
                if (wr_en && (full || busy || pos_illegal(wr_entry, 32'(NUM_QUBIT)))) err <= 1'b1;
            end
            if (abort && busy) state <= S_IDLE;
            else case (state)
                S_IDLE, S_DONE:
                    if (clear) state <= S_IDLE;
                    else if (run) begin
                        if (gate_count == '0) state <= S_DONE;
                        else begin
                            state      <= S_ISSUE;
                            gate_index <= '0;
                            meas_flags <= '0;
                            cur        <= rd_entry;
                        end
                    end else if (wr_ok) state <= S_IDLE;
                S_ISSUE: state <= S_WAIT_CANON;
                S_WAIT_CANON:
                    if (core.canonical_valid) begin
                        state    <= S_WAIT_BUF;
                        cmp_idx  <= gate_index;
                        cmp_meas <= cur.gate_type == GATE_MEAS;
                        cmp_last <= is_last;
                        if (!is_last) begin
                            gate_index <= gate_index + IDX_W'(1);
                            cur        <= rd_entry;
                        end
                    end
                S_WAIT_BUF:
                    if (core.buffer_valid) begin
                        if (cmp_meas) meas_flags <= meas_flags | (DEPTH'(core.flag_anticommute) << cmp_idx);
                        state <= cmp_last ? S_DONE : S_WAIT_CANON;
                    end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
